ex_alu_unit: RTL and testbench

Parametrised execute-stage unit that replaces the fixed add-only execute path. It accepts an operation and two XLEN-wide operands over a valid/ready handshake, and returns a registered result with its destination tag. Single-cycle ALU ops complete in one cycle; an optional iterative shift-add multiplier takes XLEN cycles. It sits between decode/register-read and writeback, with a flush input driven by branch resolution.

---
 rtl/ex_pkg.sv | 37 +++
 rtl/ex_mul_iter.sv | 88 ++++++++
 rtl/ex_alu_unit.sv | 151 +++++++++++++++
 tb/tb_ex_alu_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared types for the execute-stage unit: op codes, FSM states and the
// result record. Multiplier ops are only honoured when EX_ALU_MUL_EN is defined.
package ex_pkg;

   localparam int ALU_OP_W     = 4;
   localparam int EX_XLEN_DEF  = 32;
   localparam int EX_TAG_W_DEF = 5;

   typedef enum logic [ALU_OP_W-1:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_XOR   = 4'd4,
      OP_SLL   = 4'd5,
      OP_SRL   = 4'd6,
      OP_SRA   = 4'd7,
      OP_SLT   = 4'd8,
      OP_SLTU  = 4'd9,
      OP_MUL   = 4'd10,
      OP_MULHU = 4'd11
   } alu_op_e;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } ex_state_e;

   // Result record at the default widths; the top keeps the same three
   // fields at its own parameterised widths.
   typedef struct packed {
      logic [EX_XLEN_DEF-1:0]  result;
      logic [EX_TAG_W_DEF-1:0] tag;
      logic                    illegal;
   } ex_res_t;

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle over a
// 2*XLEN accumulator. Built only when EX_ALU_MUL_EN is defined.
`ifdef EX_ALU_MUL_EN
module ex_mul_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic            flush_i,
   input  logic            hi_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int CNT_W = $clog2(XLEN) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   logic              active_q, active_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   mcand_q, mcand_d;
   logic              hi_q, hi_d;
   logic [XLEN:0]     sum_s;
   logic [2*XLEN-1:0] acc_step_s;

   // One shift-add step: add multiplicand into the upper half when the current
   // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
   always_comb begin
      sum_s      = {1'b0, acc_q[2*XLEN-1:XLEN]}
                 + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
      acc_step_s = {sum_s, acc_q[XLEN-1:1]};
   end

   // Next-state for the iteration: flush wins, then start, then stepping.
   always_comb begin
      active_d = active_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      hi_d     = hi_q;
      if (flush_i) begin
         active_d = 1'b0;
         cnt_d    = {CNT_W{1'b0}};
      end else if (start_i) begin
         active_d = 1'b1;
         cnt_d    = {CNT_W{1'b0}};
         acc_d    = {{XLEN{1'b0}}, b_i};
         mcand_d  = a_i;
         hi_d     = hi_i;
      end else if (active_q) begin
         acc_d = acc_step_s;
         if (cnt_q == CNT_LAST) begin
            active_d = 1'b0;
            cnt_d    = {CNT_W{1'b0}};
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         active_d = active_q;
      end
   end

   // Multiplier state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active_q <= 1'b0;
         cnt_q    <= {CNT_W{1'b0}};
         acc_q    <= {(2*XLEN){1'b0}};
         mcand_q  <= {XLEN{1'b0}};
         hi_q     <= 1'b0;
      end else begin
         active_q <= active_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         hi_q     <= hi_d;
      end
   end

   // done marks the final step; the result is the post-step accumulator half.
   assign done_o   = active_q && (cnt_q == CNT_LAST);
   assign result_o = hi_q ? acc_step_s[2*XLEN-1:XLEN] : acc_step_s[XLEN-1:0];

endmodule
`endif

// File: rtl/ex_alu_unit.sv
// Execute-stage unit: single-cycle ALU plus optional iterative multiplier
// (EX_ALU_MUL_EN). Valid/ready in and out, registered result with tag.
module ex_alu_unit
   import ex_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [ALU_OP_W-1:0] op_i,
   input  logic [XLEN-1:0]     a_i,
   input  logic [XLEN-1:0]     b_i,
   input  logic [TAG_W-1:0]    tag_i,
   input  logic                flush_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [XLEN-1:0]     result_o,
   output logic [TAG_W-1:0]    tag_o,
   output logic                illegal_o,
   output logic                busy_o
);

   localparam int SH_W = $clog2(XLEN);

   ex_state_e        state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [XLEN-1:0]  result_q, result_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             illegal_q, illegal_d;
   logic [TAG_W-1:0] mul_tag_q, mul_tag_d;

   logic [SH_W-1:0]  shamt_s;
   logic [XLEN-1:0]  alu_res_s;
   logic             alu_ill_s;
   logic             is_mul_s;
   logic             accept_s;
   logic             mul_done_s;
   logic [XLEN-1:0]  mul_res_s;

   assign shamt_s    = b_i[SH_W-1:0];
   assign in_ready_o = (state_q == ST_IDLE) && (!out_valid_q || out_ready_i) && !flush_i;
   assign accept_s   = in_valid_i && in_ready_o;

   // Single-cycle ALU; anything not decoded here (incl. mul ops) reads as illegal.
   always_comb begin
      alu_res_s = {XLEN{1'b0}};
      alu_ill_s = 1'b0;
      case (op_i)
         OP_ADD:  alu_res_s = a_i + b_i;
         OP_SUB:  alu_res_s = a_i - b_i;
         OP_AND:  alu_res_s = a_i & b_i;
         OP_OR:   alu_res_s = a_i | b_i;
         OP_XOR:  alu_res_s = a_i ^ b_i;
         OP_SLL:  alu_res_s = a_i << shamt_s;
         OP_SRL:  alu_res_s = a_i >> shamt_s;
         OP_SRA:  alu_res_s = $unsigned($signed(a_i) >>> shamt_s);
         OP_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         OP_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (a_i < b_i)};
         default: alu_ill_s = 1'b1;
      endcase
   end

`ifdef EX_ALU_MUL_EN
   logic mul_start_s;

   assign is_mul_s    = (op_i == OP_MUL) || (op_i == OP_MULHU);
   assign mul_start_s = accept_s && is_mul_s;
   assign busy_o      = (state_q == ST_MUL);

   ex_mul_iter #(.XLEN(XLEN)) u_mul (
      .clk      (clk),
      .rst      (rst),
      .start_i  (mul_start_s),
      .flush_i  (flush_i),
      .hi_i     (op_i == OP_MULHU),
      .a_i      (a_i),
      .b_i      (b_i),
      .done_o   (mul_done_s),
      .result_o (mul_res_s)
   );
`else
   assign is_mul_s   = 1'b0;
   assign mul_done_s = 1'b0;
   assign mul_res_s  = {XLEN{1'b0}};
   assign busy_o     = 1'b0;
`endif

   // Control: flush first, then new accept, then multiplier completion,
   // then consumption; otherwise the output register holds.
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      tag_d       = tag_q;
      illegal_d   = illegal_q;
      mul_tag_d   = mul_tag_q;
      if (flush_i) begin
         out_valid_d = 1'b0;
         state_d     = ST_IDLE;
      end else if (accept_s) begin
         if (is_mul_s) begin
            state_d     = ST_MUL;
            mul_tag_d   = tag_i;
            out_valid_d = 1'b0;
         end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res_s;
            tag_d       = tag_i;
            illegal_d   = alu_ill_s;
         end
      end else if ((state_q == ST_MUL) && mul_done_s) begin
         state_d     = ST_IDLE;
         out_valid_d = 1'b1;
         result_d    = mul_res_s;
         tag_d       = mul_tag_q;
         illegal_d   = 1'b0;
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // FSM state and output register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         result_q    <= {XLEN{1'b0}};
         tag_q       <= {TAG_W{1'b0}};
         illegal_q   <= 1'b0;
         mul_tag_q   <= {TAG_W{1'b0}};
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         tag_q       <= tag_d;
         illegal_q   <= illegal_d;
         mul_tag_q   <= mul_tag_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign result_o    = result_q;
   assign tag_o       = tag_q;
   assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Scoreboard bench for ex_alu_unit (XLEN=32, TAG_W=5). Multiplier scenarios
// are selected with EX_ALU_MUL_EN to match the DUT build.
module tb_ex_alu_unit;

   localparam int XLEN  = 32;
   localparam int TAG_W = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready_o;
   logic [3:0]       op;
   logic [XLEN-1:0]  a, b;
   logic [TAG_W-1:0] tag;
   logic             flush;
   logic             out_valid_o;
   logic             out_ready;
   logic [XLEN-1:0]  result_o;
   logic [TAG_W-1:0] tag_o;
   logic             illegal_o;
   logic             busy_o;

   typedef struct {
      logic [XLEN-1:0]  r;
      logic [TAG_W-1:0] t;
      logic             i;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   bit   rand_rdy = 1'b0;

   ex_alu_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready_o),
      .op_i        (op),
      .a_i         (a),
      .b_i         (b),
      .tag_i       (tag),
      .flush_i     (flush),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready),
      .result_o    (result_o),
      .tag_o       (tag_o),
      .illegal_o   (illegal_o),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Independent reference model used for random traffic.
   function automatic exp_t model(input logic [3:0] o, input logic [XLEN-1:0] x,
                                  input logic [XLEN-1:0] y, input logic [TAG_W-1:0] t);
      exp_t e;
      logic [63:0] p;
      logic [4:0]  s;
      p   = {32'd0, x} * {32'd0, y};
      s   = y[4:0];
      e.t = t;
      e.i = 1'b0;
      e.r = 32'd0;
      case (o)
         4'd0:  e.r = x + y;
         4'd1:  e.r = x - y;
         4'd2:  e.r = x & y;
         4'd3:  e.r = x | y;
         4'd4:  e.r = x ^ y;
         4'd5:  e.r = x << s;
         4'd6:  e.r = x >> s;
         4'd7:  e.r = 32'($signed(x) >>> s);
         4'd8:  e.r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'd9:  e.r = (x < y) ? 32'd1 : 32'd0;
`ifdef EX_ALU_MUL_EN
         4'd10: e.r = p[31:0];
         4'd11: e.r = p[63:32];
`endif
         default: e.i = 1'b1;
      endcase
      return e;
   endfunction

   // Offer one op; push its expected result when it is accepted.
   // Entered and left just after a rising edge.
   task automatic issue(input logic [3:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                        input logic [TAG_W-1:0] t, input bit push, input logic [XLEN-1:0] er,
                        input bit eil, output int waited);
      bit   acc;
      exp_t e;
      acc = 1'b0;
      waited = 0;
      in_valid = 1'b1; op = o; a = x; b = y; tag = t;
      for (int n = 0; n < 200; n++) begin
         if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (in_ready_o) begin
            acc = 1'b1;
            break;
         end
         waited++;
         @(posedge clk); #1;
      end
      if (!acc) begin
         chk("accept_timeout", 64'd0, 64'd1);
         in_valid = 1'b0;
      end else begin
         if (push) begin
            e.r = er; e.t = t; e.i = eil;
            sb.push_back(e);
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   // Output side: compare each result on the cycle it is consumed.
   always @(negedge clk) begin
      if (rst && out_valid_o && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_out", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result",  64'(result_o),  64'(e.r));
            chk("tag",     64'(tag_o),     64'(e.t));
            chk("illegal", 64'(illegal_o), 64'(e.i));
         end
      end
   end

   typedef struct {
      logic [3:0]  o;
      logic [31:0] x, y, r;
      bit          il;
   } vec_t;

   initial begin
      vec_t vt[12];
      int   w, stalls, busy_cnt, rdy_cnt, spurious;
      exp_t e;
      vt[0]  = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
      vt[1]  = '{4'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0};
      vt[2]  = '{4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
      vt[3]  = '{4'd3,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0};
      vt[4]  = '{4'd4,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0};
      vt[5]  = '{4'd5,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0};
      vt[6]  = '{4'd6,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0};
      vt[7]  = '{4'd7,  32'h80000000, 32'h00000024, 32'hF8000000, 1'b0};
      vt[8]  = '{4'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
      vt[9]  = '{4'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
      vt[10] = '{4'd13, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1};
      vt[11] = '{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1};

      rst = 1'b0; in_valid = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0; tag = 5'd0;
      flush = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid",   64'(out_valid_o), 64'd0);
      chk("rst_result",  64'(result_o),    64'd0);
      chk("rst_tag",     64'(tag_o),       64'd0);
      chk("rst_illegal", 64'(illegal_o),   64'd0);
      chk("rst_busy",    64'(busy_o),      64'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_ready", 64'(in_ready_o), 64'd1);

      // First ADD: result visible right after the accept edge.
      issue(4'd0, 32'hFFFFFFFF, 32'h1, 5'd3, 1'b1, 32'h0, 1'b0, w);
      chk("alu_latency", 64'(out_valid_o), 64'd1);

      // Back-to-back table, no stalls expected.
      stalls = 0;
      for (int i = 0; i < 12; i++) begin
         issue(vt[i].o, vt[i].x, vt[i].y, 5'(i + 4), 1'b1, vt[i].r, vt[i].il, w);
         stalls += w;
      end
      chk("b2b_stalls", 64'(stalls), 64'd0);
      @(posedge clk); #1;

`ifdef EX_ALU_MUL_EN
      // MULHU then MUL of all-ones operands.
      for (int k = 0; k < 2; k++) begin
         issue((k == 0) ? 4'd11 : 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'(20 + k), 1'b1,
               (k == 0) ? 32'hFFFFFFFE : 32'h00000001, 1'b0, w);
         busy_cnt = 0; rdy_cnt = 0;
         for (int n = 0; n < XLEN + 10; n++) begin
            @(negedge clk);
            if (out_valid_o) break;
            busy_cnt += int'(busy_o);
            rdy_cnt  += int'(in_ready_o);
         end
         chk("mul_done",      64'(out_valid_o), 64'd1);
         chk("mul_busy_len",  64'(busy_cnt),    64'(XLEN));
         chk("mul_busy_drop", 64'(busy_o),      64'd0);
         chk("mul_ready_low", 64'(rdy_cnt),     64'd0);
         @(posedge clk); #1;
      end

      // Flush on cycle 10 of a multiply: no result, unit idle again.
      issue(4'd10, 32'd3, 32'd5, 5'd9, 1'b0, 32'd0, 1'b0, w);
      repeat (9) @(posedge clk);
      #1; flush = 1'b1;
      #1; chk("flush_no_accept", 64'(in_ready_o), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      #1;
      chk("flush_busy",  64'(busy_o),      64'd0);
      chk("flush_valid", 64'(out_valid_o), 64'd0);
      chk("flush_ready", 64'(in_ready_o),  64'd1);
      spurious = 0;
      repeat (XLEN + 4) begin
         @(negedge clk);
         spurious += int'(out_valid_o);
      end
      chk("flush_no_result", 64'(spurious), 64'd0);
      @(posedge clk); #1;

      // Reset during a multiply.
      issue(4'd11, 32'hFFFFFFFF, 32'h2, 5'd11, 1'b0, 32'd0, 1'b0, w);
      repeat (5) @(posedge clk);
      #1; rst = 1'b0;
      #1;
      chk("rst_mid_busy",  64'(busy_o),      64'd0);
      chk("rst_mid_valid", 64'(out_valid_o), 64'd0);
      @(negedge clk); rst = 1'b1;
      spurious = 0;
      repeat (XLEN + 4) begin
         @(negedge clk);
         spurious += int'(out_valid_o);
      end
      chk("rst_mid_no_result", 64'(spurious), 64'd0);
      chk("rst_mid_ready",     64'(in_ready_o), 64'd1);
      @(posedge clk); #1;
`else
      // Mul ops without the multiplier: single-cycle illegal response.
      issue(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd20, 1'b1, 32'd0, 1'b1, w);
      chk("nomul_latency", 64'(out_valid_o), 64'd1);
      chk("nomul_busy",    64'(busy_o),      64'd0);
      issue(4'd11, 32'h5, 32'h7, 5'd21, 1'b1, 32'd0, 1'b1, w);
      chk("nomul_b2b", 64'(w), 64'd0);
      @(posedge clk); #1;
`endif

      // Backpressure: result held for 4 cycles, then consumed on the same
      // edge that accepts the next op.
      out_ready = 1'b0;
      issue(4'd0, 32'd5, 32'd7, 5'd30, 1'b1, 32'd12, 1'b0, w);
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         chk("hold_valid",  64'(out_valid_o), 64'd1);
         chk("hold_result", 64'(result_o),    64'd12);
         chk("hold_tag",    64'(tag_o),       64'd30);
         chk("hold_ready",  64'(in_ready_o),  64'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      issue(4'd4, 32'hAAAA5555, 32'hFFFF0000, 5'd31, 1'b1, 32'h55555555, 1'b0, w);
      chk("release_wait",  64'(w),           64'd0);
      chk("release_valid", 64'(out_valid_o), 64'd1);

      // Random traffic with random output backpressure.
      rand_rdy = 1'b1;
      for (int i = 0; i < 60; i++) begin
         logic [3:0]       ro;
         logic [XLEN-1:0]  rx, ry;
         logic [TAG_W-1:0] rt;
         ro = 4'($urandom_range(0, 15));
         rx = $urandom; ry = $urandom; rt = 5'($urandom_range(0, 31));
         e  = model(ro, rx, ry, rt);
         issue(ro, rx, ry, rt, 1'b1, e.r, e.i, w);
      end
      rand_rdy  = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 200; n++) begin
         if (sb.size() == 0) break;
         @(posedge clk); #1;
      end
      repeat (2) @(posedge clk);
      chk("drain", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
